// File: rtl/chunked_bit_count_if.sv
// chunked_bit_count_if: valid/ready streaming bundle carrying one word in and one bit count out.
interface chunked_bit_count_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH + 1);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic in_count_zeros;
  logic out_valid;
  logic out_ready;
  logic [CW-1:0] out_count;
  modport master (
    output in_valid, in_data, in_count_zeros, out_ready,
    input in_ready, out_valid, out_count
  );
  modport slave (
    input in_valid, in_data, in_count_zeros, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/chunked_bit_count.sv
// chunked_bit_count: counts set (or clear) bits CHUNK at a time, stopping once the remaining word is zero.
module chunked_bit_count #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  chunked_bit_count_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(CHUNK + 1);
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_param
    $error("chunked_bit_count: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_pop;
  logic w_in_ready, w_out_valid, w_load;
  always_comb begin
    w_next = r_state;
    w_in_ready = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_next = bus.in_valid ? COMPUTE : IDLE;
      end
      COMPUTE: w_next = (r_data == '0) ? DONE : COMPUTE;
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready = bus.out_ready;
        w_next = !bus.out_ready ? DONE : bus.in_valid ? COMPUTE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_load = bus.in_valid && w_in_ready;
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHUNK; i++) w_pop = w_pop + PW'(r_data[i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Shifting right with zero fill lets a zero remainder end the scan early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_data <= bus.in_count_zeros ? ~bus.in_data : bus.in_data;
      r_count <= '0;
    end else if (r_state == COMPUTE && r_data != '0) begin
      r_data <= r_data >> CHUNK;
      r_count <= r_count + CW'(w_pop);
    end
  end
  assign bus.in_ready = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_chunked_bit_count.sv
// tb_chunked_bit_count: directed checks on a 32/4 instance plus randomized streams on several WIDTH/CHUNK configurations.
module tb_chunked_bit_count;
  localparam int NG = 7;
  localparam int NR = 40;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_g = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  always #5 clk = ~clk;
  chunked_bit_count_if #(.WIDTH(32)) m ();
  chunked_bit_count #(.WIDTH(32), .CHUNK(4)) u_dut (.clk(clk), .rst(rst), .bus(m.slave));
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask
  task automatic send(input logic [31:0] d, input logic z);
    int t;
    m.in_data = d;
    m.in_count_zeros = z;
    m.in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m.in_ready && t < 100);
    check("accept", m.in_ready, 1);
    @(posedge clk);
    #1 m.in_valid = 1'b0;
  endtask
  task automatic wait_res(input string tag, input int lat, input int cnt);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m.out_valid && n < 100);
    check({tag, "_lat"}, n - 1, lat);
    check({tag, "_cnt"}, m.out_count, cnt);
    @(posedge clk);
    #1;
  endtask
  initial begin
    m.in_valid = 1'b0;
    m.in_data = '0;
    m.in_count_zeros = 1'b0;
    m.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_ov", m.out_valid, 0);
    check("rst_ir", m.in_ready, 1);
    check("rst_oc", m.out_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h0000_00FF, 1'b0);
    wait_res("ff", 3, 8);
    @(negedge clk);
    check("ff_ir", m.in_ready, 1);
    check("ff_ov", m.out_valid, 0);
    @(posedge clk);
    #1;
    send(32'h0, 1'b0);
    wait_res("z1", 1, 0);
    send(32'h0, 1'b1);
    wait_res("z0", 9, 32);
    send(32'hFFFF_FFFF, 1'b0);
    wait_res("all", 9, 32);
    send(32'h8000_0000, 1'b0);
    wait_res("msb", 9, 1);
    m.out_ready = 1'b0;
    send(32'h0000_F00F, 1'b0);
    wait_res("hold", 5, 8);
    for (int i = 0; i < 5; i++) begin
      m.in_valid = 1'b1;
      m.in_data = $urandom;
      @(negedge clk);
      check("hold_ov", m.out_valid, 1);
      check("hold_oc", m.out_count, 8);
      check("hold_ir", m.in_ready, 0);
      @(posedge clk);
      #1;
    end
    m.out_ready = 1'b1;
    m.in_data = 32'h3;
    m.in_count_zeros = 1'b0;
    @(negedge clk);
    check("b2b_ir", m.in_ready, 1);
    @(posedge clk);
    #1 m.in_valid = 1'b0;
    wait_res("b2b", 2, 2);
    send(32'hFFFF_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_ov", m.out_valid, 0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ov", m.out_valid, 0);
    check("mid_rst_oc", m.out_count, 0);
    check("mid_rst_ir", m.in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h1, 1'b0);
    wait_res("post_rst", 2, 1);
    for (int t = 0; t < 40000 && done_cnt < NG; t++) @(posedge clk);
    check("rnd_done", done_cnt, NG);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2 rst_g = 1'b1;
    #20 rst_g = 1'b0;
  end
  for (genvar g = 0; g < NG; g++) begin : g_rnd
    localparam int W = (g < 3) ? 8 : 32;
    localparam int C = (g == 6) ? 4 : (g % 3 == 0) ? 1 : (g % 3 == 1) ? 2 : 8;
    chunked_bit_count_if #(.WIDTH(W)) b ();
    chunked_bit_count #(.WIDTH(W), .CHUNK(C)) u (.clk(clk), .rst(rst_g), .bus(b.slave));
    int q[$];
    int got = 0;
    initial begin : prod
      logic [W-1:0] d;
      logic z;
      int t;
      b.in_valid = 1'b0;
      b.in_data = '0;
      b.in_count_zeros = 1'b0;
      @(negedge rst_g);
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        d = W'($urandom) >> $urandom_range(0, W);
        z = 1'($urandom);
        b.in_data = d;
        b.in_count_zeros = z;
        b.in_valid = 1'b1;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!b.in_ready && t < 500);
        if (!b.in_ready) check($sformatf("rnd%0d_acc", g), 0, 1);
        q.push_back(z ? W - $countones(d) : $countones(d));
        @(posedge clk);
        #1 b.in_valid = 1'b0;
      end
    end
    initial begin : cons
      int e;
      b.out_ready = 1'b0;
      @(negedge rst_g);
      for (int t = 0; t < 20000 && got < NR; t++) begin
        @(negedge clk);
        if (b.out_valid && b.out_ready) begin
          e = (q.size() > 0) ? q.pop_front() : -1;
          check($sformatf("rnd%0d_cnt", g), 64'(b.out_count), 64'(e));
          got++;
        end
        @(posedge clk);
        #1 b.out_ready = ($urandom % 3) != 0;
      end
      check($sformatf("rnd%0d_num", g), got, NR);
      check($sformatf("rnd%0d_left", g), q.size(), 0);
      done_cnt++;
    end
  end
endmodule

// File: doc/chunked_bit_count.md
Name: chunked_bit_count

Overview:
- Parametrised successor to the single-bit asserted-bit-count FSMDs.
- Counts set bits (or clear bits, selected per transaction) of a WIDTH-bit word.
- Examines CHUNK bits per cycle and exits early once the remaining word is zero.
- Uses valid/ready handshakes on both input and output, so it drops into streaming datapaths without external go/done glue.

Parameters:
- WIDTH, 32, input word width in bits; must be ≥1.
- CHUNK, 4, bits examined per COMPUTE cycle; must satisfy 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0 (elaboration-time check fails otherwise).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data/in_count_zeros are valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  word to be counted.
- in_count_zeros  in  1  0 = count '1' bits; 1 = count '0' bits. Sampled with in_data.
- out_valid  out  1  out_count holds a completed result.
- out_ready  in  1  consumer accepts the result.
- out_count  out  $clog2(WIDTH+1)  number of matching bits.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE; count_r = 0; data_r = 0.
  - out_valid = 0, out_count = 0, in_ready = 1.
  - Any in-flight word is discarded and no result is produced for it.
- Input transfer occurs on a rising edge where in_valid && in_ready. Output transfer occurs on a rising edge where out_valid && out_ready.
- States are IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On input transfer: data_r <= in_count_zeros ? ~in_data : in_data; count_r <= 0; go to COMPUTE.
- COMPUTE:
  - in_ready = 0, out_valid = 0.
  - If data_r == 0: go to DONE; count_r is unchanged.
  - Else: count_r <= count_r + popcount(data_r[CHUNK-1:0]); data_r <= data_r >> CHUNK (logical shift, zero fill); remain in COMPUTE.
- DONE:
  - out_valid = 1.
  - in_ready = out_ready, so a new word is accepted in the same cycle the result is taken.
  - On output transfer without input transfer: go to IDLE.
  - On output and input transfer in the same edge: load data_r/count_r exactly as in IDLE and go directly to COMPUTE.
  - While out_ready = 0: out_count and out_valid hold stable; in_valid is ignored.
- out_count = count_r at all times. It is only meaningful while out_valid = 1.
- Latency:
  - Let k = index of the highest nonzero CHUNK-slice of the (possibly inverted) word, plus 1; k = 0 for a zero word.
  - out_valid rises k+1 cycles after the input-transfer edge.
  - Range: 1 (zero word) to WIDTH/CHUNK + 1 cycles.
- Width rules:
  - The per-chunk popcount is $clog2(CHUNK+1) bits, zero-extended to count width.
  - The sum cannot overflow because the maximum total is WIDTH and the count width is $clog2(WIDTH+1).
- CHUNK == WIDTH is legal: one add cycle plus one terminate cycle.
- in_data changes while in_ready = 0 have no effect.

Test Plan:
- WIDTH=32, CHUNK=4; send in_data=0x000000FF, count ones, out_ready=1 -> out_valid 3 cycles after acceptance, out_count=8, then in_ready=1 next cycle.
- in_data=0x00000000, count ones -> out_valid 1 cycle after acceptance, out_count=0. Same word with in_count_zeros=1 -> out_count=32 after 9 cycles.
- in_data=0xFFFFFFFF, count ones -> out_count=32 after 9 cycles (max latency, max count, no overflow). Also in_data=0x80000000 -> out_count=1 after 9 cycles (highest slice only).
- Hold out_ready=0 for 5 cycles after out_valid with in_data=0x0000F00F -> out_count stays 8, in_ready stays 0, in_valid ignored. Then raise out_ready together with in_valid and in_data=0x3 -> back-to-back accept, next out_count=2.
- Assert rst during COMPUTE of 0xFFFFFFFF -> out_valid=0, out_count=0, in_ready=1 immediately. After release, a new word 0x1 returns out_count=1 with no residue.
- Random regression with WIDTH ∈ {8, 32}, CHUNK ∈ {1, 2, 8}, random stalls on both sides -> every result matches the reference popcount (or WIDTH−popcount in zeros mode), in order, none lost or duplicated.
